// File: rtl/i2c_regfile_slave_if.sv
// Host-side port bundle of the I2C register-file target.
//   i_slave_addr : own 7-bit bus address
//   i_host_addr  : local read index into the register file
//   o_host_data  : registered register contents at i_host_addr
//   o_wr_en      : one-cycle strobe per byte written from the bus
//   o_reg_addr   : register index of the last bus access
//   o_wr_data    : last byte written from the bus
//   o_rd_done    : one-cycle strobe per read byte acknowledged by the master
//   o_busy       : target addressed and transaction in progress
interface i2c_regfile_slave_if;
    logic [6:0] i_slave_addr;
    logic [7:0] i_host_addr;
    logic [7:0] o_host_data;
    logic       o_wr_en;
    logic [7:0] o_reg_addr;
    logic [7:0] o_wr_data;
    logic       o_rd_done;
    logic       o_busy;

    modport slave (
        input  i_slave_addr, i_host_addr,
        output o_host_data, o_wr_en, o_reg_addr, o_wr_data, o_rd_done, o_busy
    );

    modport master (
        output i_slave_addr, i_host_addr,
        input  o_host_data, o_wr_en, o_reg_addr, o_wr_data, o_rd_done, o_busy
    );
endinterface

// File: rtl/i2c_regfile_slave.sv
// I2C target owning a DEPTH x 8 register file with an auto-incrementing
// pointer. Oversamples SCL/SDA on clk, decodes START/STOP, matches its
// address, accepts pointer + data bytes on writes and serves bytes on reads.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   scl   : I2C clock (never stretched)
//   sda   : I2C data, open drain (driven low or released)
//   host  : host read port, write mirror and status (i2c_regfile_slave_if)
module i2c_regfile_slave #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    inout  wire  sda,
    i2c_regfile_slave_if.slave host
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
    } state_t;

    // [0],[1]: two-flop synchronizer, [2]: delayed copy for edge detection.
    // Reset to 1 (idle bus level) so no false event follows reset.
    logic [2:0] scl_pipe_reg, sda_pipe_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_pipe_reg <= '1;
            sda_pipe_reg <= '1;
        end else begin
            scl_pipe_reg <= {scl_pipe_reg[1:0], scl};
            sda_pipe_reg <= {sda_pipe_reg[1:0], sda};
        end
    end

    logic scl_s, scl_d, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_s     = scl_pipe_reg[1];
    assign scl_d     = scl_pipe_reg[2];
    assign sda_s     = sda_pipe_reg[1];
    assign sda_d     = sda_pipe_reg[2];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    state_t         state_reg, state_next;
    logic [3:0]     bit_cnt_reg, bit_cnt_next;   // rising edges seen in the 9-bit frame
    logic [7:0]     shift_reg, shift_next;
    logic [PW-1:0]  ptr_reg, ptr_next;
    logic           rw_reg, rw_next;
    logic           sda_oe_reg, sda_oe_next;     // 1 = pull SDA low
    logic           busy_reg, busy_next;
    logic           wr_en_reg, wr_en_next;
    logic           rd_done_reg, rd_done_next;
    logic [7:0]     reg_addr_reg, reg_addr_next;
    logic [7:0]     wr_data_reg, wr_data_next;
    logic           mem_we;
    logic [7:0]     rx_byte;

    logic [7:0]     mem_reg [DEPTH];
    logic [7:0]     rd_word_reg;                 // mem[ptr], refreshed every cycle
    logic [7:0]     host_data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            ptr_reg      <= '0;
            rw_reg       <= 1'b0;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            wr_en_reg    <= 1'b0;
            rd_done_reg  <= 1'b0;
            reg_addr_reg <= '0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            ptr_reg      <= ptr_next;
            rw_reg       <= rw_next;
            sda_oe_reg   <= sda_oe_next;
            busy_reg     <= busy_next;
            wr_en_reg    <= wr_en_next;
            rd_done_reg  <= rd_done_next;
            reg_addr_reg <= reg_addr_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    // Register file; reads are registered so a same-cycle bus write is
    // seen by the host only on the following read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
            rd_word_reg   <= '0;
            host_data_reg <= '0;
        end else begin
            if (mem_we) mem_reg[ptr_reg] <= rx_byte;
            rd_word_reg   <= mem_reg[ptr_reg];
            host_data_reg <= mem_reg[host.i_host_addr[PW-1:0]];
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        ptr_next      = ptr_reg;
        rw_next       = rw_reg;
        sda_oe_next   = sda_oe_reg;
        busy_next     = busy_reg;
        wr_en_next    = 1'b0;
        rd_done_next  = 1'b0;
        reg_addr_next = reg_addr_reg;
        wr_data_next  = wr_data_reg;
        mem_we        = 1'b0;
        rx_byte       = {shift_reg[6:0], sda_s};

        if (stop_det) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
        end else if (scl_rise) begin
            unique case (state_reg)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    shift_next   = rx_byte;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd7) begin
                        if (state_reg == ST_ADDR) begin
                            if (rx_byte[7:1] == host.i_slave_addr) begin
                                state_next = ST_ADDR_ACK;
                                rw_next    = rx_byte[0];
                                busy_next  = 1'b1;
                            end else begin
                                state_next = ST_WAIT_STOP;
                            end
                        end else if (state_reg == ST_PTR) begin
                            ptr_next   = rx_byte[PW-1:0];
                            state_next = ST_PTR_ACK;
                        end else begin
                            mem_we        = 1'b1;
                            wr_en_next    = 1'b1;
                            reg_addr_next = 8'(ptr_reg);
                            wr_data_next  = rx_byte;
                            ptr_next      = ptr_reg + 1'b1;
                            state_next    = ST_WR_ACK;
                        end
                    end
                end
                ST_RD_DATA: begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd7) state_next = ST_RD_ACK;
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (bit_cnt_reg == 4'd8) bit_cnt_next = 4'd9;
                end
                ST_RD_ACK: begin
                    // Master's acknowledge bit for the byte just served.
                    if (bit_cnt_reg == 4'd8) begin
                        bit_cnt_next = 4'd9;
                        ptr_next     = ptr_reg + 1'b1;
                        if (!sda_s) begin
                            rd_done_next  = 1'b1;
                            reg_addr_next = 8'(ptr_reg);
                        end else begin
                            state_next = ST_WAIT_STOP;
                            busy_next  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            unique case (state_reg)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    // First fall opens the ACK slot, second fall closes it.
                    if (bit_cnt_reg == 4'd8) begin
                        sda_oe_next = 1'b1;
                    end else if (bit_cnt_reg == 4'd9) begin
                        bit_cnt_next = '0;
                        sda_oe_next  = 1'b0;
                        if (state_reg == ST_ADDR_ACK && rw_reg) begin
                            state_next  = ST_RD_DATA;
                            shift_next  = rd_word_reg;
                            sda_oe_next = ~rd_word_reg[7];
                        end else if (state_reg == ST_ADDR_ACK) begin
                            state_next = ST_PTR;
                        end else begin
                            state_next = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (bit_cnt_reg != 4'd0) begin
                        shift_next  = {shift_reg[6:0], 1'b0};
                        sda_oe_next = ~shift_reg[6];
                    end
                end
                ST_RD_ACK: begin
                    if (bit_cnt_reg == 4'd8) begin
                        sda_oe_next = 1'b0;
                    end else if (bit_cnt_reg == 4'd9) begin
                        state_next   = ST_RD_DATA;
                        bit_cnt_next = '0;
                        shift_next   = rd_word_reg;
                        sda_oe_next  = ~rd_word_reg[7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda = sda_oe_reg ? 1'b0 : 1'bz;

    assign host.o_host_data = host_data_reg;
    assign host.o_wr_en     = wr_en_reg;
    assign host.o_reg_addr  = reg_addr_reg;
    assign host.o_wr_data   = wr_data_reg;
    assign host.o_rd_done   = rd_done_reg;
    assign host.o_busy      = busy_reg;

    // Host index bits above PW do not select anything.
    logic unused_host_bits;
    assign unused_host_bits = ^(host.i_host_addr >> PW);
endmodule
